store_buffer: RTL and testbench

- Posted-write buffer directly downstream of the store byte-lane masker.
- Accepts word-aligned stores as {address, lane-replicated data, 4-bit byte mask} and queues them in a DEPTH-entry FIFO.
- Drains entries to the data memory over a req/ack handshake, so the pipeline does not stall on memory write latency.
- Merges consecutive stores to the same word, and flags loads that hit a pending store so the hazard unit can stall them.

---
 rtl/store_buffer.sv | 96 +++++++++
 tb/tb_store_buffer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-write store buffer: FIFO of word-aligned stores drained to data memory
// over req/ack, with youngest-entry merging and load-hazard detection.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic [3:0]        st_mask,
    output logic              st_ready,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_ack,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_conflict,
    output logic              empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WA_W  = ADDR_W - 2;
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] TWO  = (PTR_W + 1)'(2);

    logic [WA_W-1:0]  ent_addr [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [3:0]       ent_mask [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr, tail, offs;
    logic [PTR_W:0]   count;
    logic [WA_W-1:0]  st_word, ld_word;
    logic             pop, accept, merge, alloc;

    assign st_word  = st_addr[ADDR_W-1:2];
    assign ld_word  = ld_addr[ADDR_W-1:2];
    assign tail     = wr_ptr - PTR_W'(1);
    assign st_ready = (count != FULL);
    assign mem_req  = (count != '0);
    assign empty    = (count == '0);
    assign pop      = mem_req && mem_ack;
    assign accept   = st_valid && st_ready && (st_mask != 4'b0000);
    // count >= 2 guarantees the tail is not the head, which may be mid-handshake
    assign merge    = accept && (count >= TWO) && (ent_addr[tail] == st_word);
    assign alloc    = accept && !merge;

    assign mem_addr  = mem_req ? {ent_addr[rd_ptr], 2'b00} : '0;
    assign mem_wdata = mem_req ? ent_data[rd_ptr] : '0;
    assign mem_wmask = mem_req ? ent_mask[rd_ptr] : '0;

    always_comb begin
        ld_conflict = 1'b0;
        offs        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PTR_W'(i) - rd_ptr;
            if (({1'b0, offs} < count) && (ent_addr[i] == ld_word))
                ld_conflict = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
                ent_mask[i] <= '0;
            end
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (alloc) begin
                ent_addr[wr_ptr] <= st_word;
                ent_data[wr_ptr] <= st_data;
                ent_mask[wr_ptr] <= st_mask;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end else if (merge) begin
                for (int b = 0; b < 4; b++) begin
                    if (st_mask[b]) begin
                        ent_data[tail][8*b +: 8] <= st_data[8*b +: 8];
                        ent_mask[tail][b]        <= 1'b1;
                    end
                end
            end
            if (alloc && !pop)
                count <= count + (PTR_W + 1)'(1);
            else if (!alloc && pop)
                count <= count - (PTR_W + 1)'(1);
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed, table-driven bench for store_buffer plus hand sequences for
// full/wrap and reset-during-ack.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_mask;
    logic        st_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ack;
    logic [31:0] ld_addr;
    logic        ld_conflict;
    logic        empty;

    int n_vec = 0;
    int n_bad = 0;

    logic [63:0] wr_log [$];

    store_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .st_valid    (st_valid),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_mask     (st_mask),
        .st_ready    (st_ready),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wmask   (mem_wmask),
        .mem_ack     (mem_ack),
        .ld_addr     (ld_addr),
        .ld_conflict (ld_conflict),
        .empty       (empty)
    );

    always #5 clk = ~clk;

    // Memory-side record of every accepted write: {addr, data}
    always @(posedge clk) begin
        if (rst_n && mem_req && mem_ack)
            wr_log.push_back({mem_addr, mem_wdata});
    end

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
        logic        ack;
        logic [31:0] ld;
        logic        req;
        logic [31:0] ea;
        logic [31:0] ed;
        logic [3:0]  em;
        logic        emp;
        logic        rdy;
        logic        conf;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic ack, input logic [31:0] ld,
                       input logic req, input logic [31:0] ea, input logic [31:0] ed,
                       input logic [3:0] em, input logic emp, input logic rdy,
                       input logic conf);
        vec_t r;
        r.v = v; r.a = a; r.d = d; r.m = m; r.ack = ack; r.ld = ld;
        r.req = req; r.ea = ea; r.ed = ed; r.em = em;
        r.emp = emp; r.rdy = rdy; r.conf = conf;
        tbl.push_back(r);
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        st_valid = 1'b1; st_addr = a; st_data = d; st_mask = m;
        step();
        st_valid = 1'b0; st_mask = 4'b0000;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_addr [5];
        int          cyc;

        rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_mask = '0;
        mem_ack = 1'b0; ld_addr = '0;
        #2;
        check("reset_outputs",
              {mem_req, mem_addr, mem_wdata, mem_wmask, ld_conflict, empty, st_ready},
              {1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1});
        step(); step();
        rst_n = 1'b1;

        //   v     addr          data          mask     ack   ld_addr     req   mem_addr      mem_wdata     wmask    emp   rdy   conf
        add(1'b1, 32'h100, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h0,   1'b1, 32'h100, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b1, 1'b0);
        add(1'b1, 32'h204, 32'h12341234, 4'b1100, 1'b0, 32'h0,   1'b1, 32'h100, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b1, 1'b0);
        add(1'b1, 32'h30B, 32'hABABABAB, 4'b1000, 1'b0, 32'h207, 1'b1, 32'h100, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b1, 1'b1);
        add(1'b0, 32'h0,   32'h0,        4'b0000, 1'b0, 32'h208, 1'b1, 32'h100, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b1, 1'b0);
        add(1'b0, 32'h0,   32'h0,        4'b0000, 1'b1, 32'h100, 1'b1, 32'h204, 32'h12341234, 4'b1100, 1'b0, 1'b1, 1'b0);
        add(1'b0, 32'h0,   32'h0,        4'b0000, 1'b1, 32'h0,   1'b1, 32'h308, 32'hABABABAB, 4'b1000, 1'b0, 1'b1, 1'b0);
        add(1'b0, 32'h0,   32'h0,        4'b0000, 1'b1, 32'h0,   1'b0, 32'h0,   32'h0,        4'b0000, 1'b1, 1'b1, 1'b0);
        add(1'b0, 32'h0,   32'h0,        4'b0000, 1'b1, 32'h0,   1'b0, 32'h0,   32'h0,        4'b0000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 32'h100, 32'h11111111, 4'b1111, 1'b0, 32'h0,   1'b1, 32'h100, 32'h11111111, 4'b1111, 1'b0, 1'b1, 1'b0);
        add(1'b1, 32'h201, 32'h55555555, 4'b0010, 1'b0, 32'h200, 1'b1, 32'h100, 32'h11111111, 4'b1111, 1'b0, 1'b1, 1'b1);
        add(1'b1, 32'h203, 32'h77777777, 4'b1000, 1'b0, 32'h0,   1'b1, 32'h100, 32'h11111111, 4'b1111, 1'b0, 1'b1, 1'b0);
        add(1'b0, 32'h0,   32'h0,        4'b0000, 1'b1, 32'h0,   1'b1, 32'h200, 32'h77555555, 4'b1010, 1'b0, 1'b1, 1'b0);
        add(1'b0, 32'h0,   32'h0,        4'b0000, 1'b1, 32'h0,   1'b0, 32'h0,   32'h0,        4'b0000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 32'h400, 32'hAAAAAAAA, 4'b1111, 1'b0, 32'h0,   1'b1, 32'h400, 32'hAAAAAAAA, 4'b1111, 1'b0, 1'b1, 1'b0);
        add(1'b1, 32'h400, 32'h000000BB, 4'b0001, 1'b0, 32'h0,   1'b1, 32'h400, 32'hAAAAAAAA, 4'b1111, 1'b0, 1'b1, 1'b0);
        add(1'b0, 32'h0,   32'h0,        4'b0000, 1'b1, 32'h0,   1'b1, 32'h400, 32'h000000BB, 4'b0001, 1'b0, 1'b1, 1'b0);
        add(1'b0, 32'h0,   32'h0,        4'b0000, 1'b1, 32'h0,   1'b0, 32'h0,   32'h0,        4'b0000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 32'h500, 32'h01020304, 4'b1111, 1'b0, 32'h0,   1'b1, 32'h500, 32'h01020304, 4'b1111, 1'b0, 1'b1, 1'b0);
        add(1'b1, 32'h500, 32'h0000EE00, 4'b0010, 1'b1, 32'h0,   1'b1, 32'h500, 32'h0000EE00, 4'b0010, 1'b0, 1'b1, 1'b0);
        add(1'b1, 32'h600, 32'hCAFEF00D, 4'b1111, 1'b1, 32'h0,   1'b1, 32'h600, 32'hCAFEF00D, 4'b1111, 1'b0, 1'b1, 1'b0);
        add(1'b0, 32'h0,   32'h0,        4'b0000, 1'b1, 32'h0,   1'b0, 32'h0,   32'h0,        4'b0000, 1'b1, 1'b1, 1'b0);

        foreach (tbl[i]) begin
            st_valid = tbl[i].v; st_addr = tbl[i].a; st_data = tbl[i].d; st_mask = tbl[i].m;
            mem_ack  = tbl[i].ack; ld_addr = tbl[i].ld;
            step();
            st_valid = 1'b0; st_mask = 4'b0000; mem_ack = 1'b0;
            #1;
            check($sformatf("row%0d", i),
                  {mem_req, mem_addr, mem_wdata, mem_wmask, empty, st_ready, ld_conflict},
                  {tbl[i].req, tbl[i].ea, tbl[i].ed, tbl[i].em, tbl[i].emp, tbl[i].rdy, tbl[i].conf});
        end

        // Full, blocked 5th store, wrap of wr_ptr back to slot 0
        ld_addr = '0;
        pulse_reset();
        wr_log.delete();
        store(32'h1000, 32'h00001000, 4'b1111);
        store(32'h1004, 32'h00001004, 4'b1111);
        store(32'h1008, 32'h00001008, 4'b1111);
        store(32'h100C, 32'h0000100C, 4'b1111);
        check("full_not_ready", {31'b0, st_ready}, 32'd0);
        store(32'h1010, 32'h00001010, 4'b1111);
        check("blocked_head", {st_ready, mem_addr}, {1'b0, 32'h1000});
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("slot_freed", {st_ready, mem_addr}, {1'b1, 32'h1004});
        store(32'h1014, 32'h00001014, 4'b1111);
        check("full_after_wrap", {31'b0, st_ready}, 32'd0);
        mem_ack = 1'b1;
        cyc = 0;
        while (!empty && cyc < 10) begin
            step();
            cyc++;
        end
        mem_ack = 1'b0;
        check("drain_bound", {31'b0, empty}, 32'd1);
        exp_addr[0] = 32'h1000; exp_addr[1] = 32'h1004; exp_addr[2] = 32'h1008;
        exp_addr[3] = 32'h100C; exp_addr[4] = 32'h1014;
        check("wrap_write_count", 128'(wr_log.size()), 128'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < wr_log.size())
                check($sformatf("wrap_order%0d", k), {64'b0, wr_log[k]}, {64'b0, exp_addr[k], exp_addr[k]});
        end

        // Reset while the second of two entries is being acked
        wr_log.delete();
        store(32'h700, 32'h00000700, 4'b1111);
        store(32'h704, 32'h00000704, 4'b1111);
        mem_ack = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        check("reset_mid_ack", {30'b0, mem_req, empty}, {30'b0, 1'b0, 1'b1});
        step();
        rst_n = 1'b1;
        step(); step();
        mem_ack = 1'b0;
        check("no_write_after_reset", 128'(wr_log.size()), 128'd1);
        check("still_empty", {30'b0, mem_req, empty}, {30'b0, 1'b0, 1'b1});

        store(32'h800, 32'h12345678, 4'b0000);
        check("zero_mask_discard", {29'b0, mem_req, empty, st_ready}, {29'b0, 1'b0, 1'b1, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
